// File: rtl/nios_system_pio_out.sv
// Avalon-MM output PIO with atomic set/clear/toggle and an optional per-bit blink engine.
// The blink engine is built only when NIOS_PIO_OUT_BLINK_EN is defined; otherwise out_port = DATA.

module nios_system_pio_out_lane (
  input  logic data,
  input  logic mask,
  input  logic phase,
  output logic q
);
  // Blinking bits show DATA in phase 0 and are forced low in phase 1.
  assign q = data & ~(mask & phase);
endmodule

module nios_system_pio_out #(
  parameter int unsigned                DATA_WIDTH  = 8,
  parameter int unsigned                PRESCALE_W  = 24,
  parameter logic [DATA_WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA     = 3'd0;
  localparam logic [2:0] A_MASK     = 3'd1;
  localparam logic [2:0] A_PERIOD   = 3'd2;
  localparam logic [2:0] A_STATUS   = 3'd3;
  localparam logic [2:0] A_OUTSET   = 3'd4;
  localparam logic [2:0] A_OUTCLEAR = 3'd5;
  localparam logic [2:0] A_TOGGLE   = 3'd6;

  logic                  wr;
  logic [DATA_WIDTH-1:0] wd_data;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] blink_mask;
  logic                  phase;
  logic                  unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd_data   = writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_VALUE;
    end else if (wr) begin
      case (address)
        A_DATA:     data_q <= wd_data;
        A_OUTSET:   data_q <= data_q | wd_data;
        A_OUTCLEAR: data_q <= data_q & ~wd_data;
        A_TOGGLE:   data_q <= data_q ^ wd_data;
        default:    data_q <= data_q;
      endcase
    end
  end

`ifdef NIOS_PIO_OUT_BLINK_EN
  logic [PRESCALE_W-1:0] period;
  logic [PRESCALE_W-1:0] cnt;
  logic [PRESCALE_W-1:0] wd_period;

  assign wd_period = writedata[PRESCALE_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_mask <= '0;
      period     <= '0;
      cnt        <= '0;
      phase      <= 1'b0;
    end else begin
      if (wr && address == A_MASK) blink_mask <= wd_data;
      // A PERIOD write restarts the half-period and wins over a terminal count.
      if (wr && address == A_PERIOD) begin
        period <= wd_period;
        cnt    <= wd_period;
        phase  <= 1'b0;
      end else if (period == '0) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (cnt == '0) begin
        cnt   <= period;
        phase <= ~phase;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:   readdata = 32'(data_q);
      A_MASK:   readdata = 32'(blink_mask);
      A_PERIOD: readdata = 32'(period);
      A_STATUS: readdata = {31'b0, phase};
      default:  readdata = '0;
    endcase
  end
`else
  assign blink_mask = '0;
  assign phase      = 1'b0;

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:  readdata = 32'(data_q);
      default: readdata = '0;
    endcase
  end
`endif

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
    nios_system_pio_out_lane u_lane (
      .data  (data_q[i]),
      .mask  (blink_mask[i]),
      .phase (phase),
      .q     (out_port[i])
    );
  end

endmodule

// File: tb/tb_nios_system_pio_out.sv
// Scoreboard bench for nios_system_pio_out: stimulus queues expectations, a negedge monitor checks them.
module tb_nios_system_pio_out;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [7:0]  exp_out;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } exp_t;

  exp_t q[$];

  nios_system_pio_out #(
    .DATA_WIDTH  (8),
    .PRESCALE_W  (8),
    .RESET_VALUE (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  // Monitor: every queued expectation is checked against the settled outputs at negedge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (out_port !== e.exp_out) begin
        failures++;
        $display("FAIL %s out_port got=%h exp=%h", e.name, out_port, e.exp_out);
      end
      if (e.chk_rd) begin
        checks++;
        if (readdata !== e.exp_rd) begin
          failures++;
          $display("FAIL %s readdata[a=%0d] got=%h exp=%h", e.name, address, readdata, e.exp_rd);
        end
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic chk(input string name, input logic [7:0] eo, input bit crd,
                     input logic [2:0] a, input logic [31:0] er);
    exp_t e;
    address  = a;
    e.name   = name;
    e.exp_out = eo;
    e.chk_rd = crd;
    e.exp_rd = er;
    q.push_back(e);
    @(negedge clk); #1;
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

`ifdef NIOS_PIO_OUT_BLINK_EN
  logic [7:0] blink3 [12] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE,
                              8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] blink5 [8]  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFE};
`endif

  initial begin
    reset = 1'b1;
    adv(); adv();
    reset = 1'b0;
    chk("reset_out", 8'hA5, 1, 3'd0, 32'h0000_00A5);

    wr(3'd0, 32'h0000_01FF);
    chk("data_trunc", 8'hFF, 1, 3'd0, 32'h0000_00FF);

    wr(3'd0, 32'h0000_000F);
    chk("data_0f", 8'h0F, 0, 3'd0, 32'h0);
    wr(3'd4, 32'h0000_0030);
    chk("outset", 8'h3F, 1, 3'd4, 32'h0);
    wr(3'd5, 32'h0000_0003);
    chk("outclear", 8'h3C, 1, 3'd5, 32'h0);
    wr(3'd6, 32'h0000_0081);
    chk("toggle", 8'hBD, 1, 3'd6, 32'h0);
    chk("rd7", 8'hBD, 1, 3'd7, 32'h0);

    // Writes that must not land.
    address = 3'd0; writedata = 32'h0; chipselect = 1'b0; write_n = 1'b0;
    adv();
    write_n = 1'b1;
    chk("cs_low_ignored", 8'hBD, 1, 3'd0, 32'h0000_00BD);
    address = 3'd0; chipselect = 1'b1; write_n = 1'b1;
    adv();
    chipselect = 1'b0;
    chk("wn_high_ignored", 8'hBD, 1, 3'd0, 32'h0000_00BD);
    wr(3'd7, 32'hFFFF_FFFF);
    chk("rsvd_wr_ignored", 8'hBD, 1, 3'd0, 32'h0000_00BD);

`ifdef NIOS_PIO_OUT_BLINK_EN
    wr(3'd0, 32'hFF);
    wr(3'd1, 32'h01);
    chk("mask_rd", 8'hFF, 1, 3'd1, 32'h01);
    wr(3'd2, 32'h03);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("blink3_%0d", k), blink3[k], 1, 3'd3, (blink3[k] == 8'hFF) ? 32'h0 : 32'h1);
      if (k < 11) adv();
    end
    // cnt is 0 here; the PERIOD write lands on the would-be toggle edge.
    wr(3'd2, 32'h05);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("blink5_%0d", k), blink5[k], 1, 3'd3, (blink5[k] == 8'hFF) ? 32'h0 : 32'h1);
      if (k < 7) adv();
    end
    wr(3'd2, 32'h00);
    chk("period0_out", 8'hFF, 1, 3'd3, 32'h0);
    adv();
    chk("period0_hold", 8'hFF, 1, 3'd2, 32'h0);
    wr(3'd2, 32'h02);
    adv(); adv(); adv();
    chk("blink2_ph1", 8'hFE, 1, 3'd3, 32'h1);
`else
    wr(3'd1, 32'hFF);
    chk("nb_mask_rd", 8'hBD, 1, 3'd1, 32'h0);
    wr(3'd2, 32'h01);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("nb_steady_%0d", k), 8'hBD, 1, 3'd2, 32'h0);
      adv();
    end
    chk("nb_status_rd", 8'hBD, 1, 3'd3, 32'h0);
`endif

    // Reset collides with a DATA write while (possibly) blinking.
    reset = 1'b1; address = 3'd0; writedata = 32'h55; chipselect = 1'b1; write_n = 1'b0;
    adv();
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    chk("rst_wr_data", 8'hA5, 1, 3'd0, 32'h0000_00A5);
    chk("rst_wr_mask", 8'hA5, 1, 3'd1, 32'h0);
    chk("rst_wr_period", 8'hA5, 1, 3'd2, 32'h0);
    chk("rst_wr_status", 8'hA5, 1, 3'd3, 32'h0);
    adv(); adv();
    chk("rst_wr_steady", 8'hA5, 1, 3'd3, 32'h0);

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
